// File: rtl/gba_video_scan.sv
// Scan-out of the 240x160 GBA framebuffer to raster video with pixel enable,
// RGB888, syncs and blanking; frame start is locked to the core's last-pixel write.
module gba_video_scan #(
   parameter int DIV        = 4,
   parameter int H_ACTIVE   = 240,
   parameter int H_TOTAL    = 256,
   parameter int HS_START   = 244,
   parameter int HS_END     = 252,
   parameter int V_ACTIVE   = 160,
   parameter int V_TOTAL    = 256,
   parameter int VS_START   = 163,
   parameter int VS_END     = 166,
   parameter int FRAME_LAST = 38399,
   parameter int WAIT_MAX   = 65535
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        pixel_we,
   input  logic [15:0] pixel_addr,
   output logic [15:0] rd_addr,
   input  logic [14:0] rd_data,
   output logic        ce_pix,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        hs,
   output logic        vs,
   output logic        hblank,
   output logic        vblank,
   output logic        de
);

   localparam int DW = $clog2(DIV);
   localparam int XW = $clog2(H_TOTAL);
   localparam int YW = $clog2(V_TOTAL);
   localparam int WW = $clog2(WAIT_MAX + 1);

   localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
   localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] X_HS0  = XW'(HS_START);
   localparam logic [XW-1:0] X_HS1  = XW'(HS_END);
   localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] Y_VS0  = YW'(VS_START);
   localparam logic [YW-1:0] Y_VS1  = YW'(VS_END);
   localparam logic [WW-1:0] W_MAX  = WW'(WAIT_MAX);
   localparam logic [15:0]   A_LAST = 16'(FRAME_LAST);

   localparam logic [0:0] ST_WAIT = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   // 5-bit channel to 8 bits by replicating the top bits into the low end
   function automatic logic [7:0] expand5(input logic [4:0] c);
      expand5 = {c, c[4:2]};
   endfunction

   logic [0:0]    state_r, state_s;
   logic [DW-1:0] div_r, div_s;
   logic [WW-1:0] wcnt_r, wcnt_s;
   logic [XW-1:0] x_r, x_s;
   logic [YW-1:0] y_r, y_s;
   logic          sync_r, sync_s, sync_set_s, sync_clr_s;
   logic [15:0]   addr_s;
   logic [7:0]    r_s, g_s, b_s;
   logic          hs_s, vs_s, hblank_s, vblank_s;
   logic          x_blank_s, y_blank_s, x_sync_s, y_sync_s, active_s;

   assign x_blank_s  = (x_r >= X_ACT);
   assign y_blank_s  = (y_r >= Y_ACT);
   assign x_sync_s   = (x_r >= X_HS0) && (x_r < X_HS1);
   assign y_sync_s   = (y_r >= Y_VS0) && (y_r < Y_VS1);
   assign active_s   = ~x_blank_s & ~y_blank_s;
   assign sync_set_s = pixel_we & (pixel_addr == A_LAST);
   assign de         = ~(hblank | vblank);

   // Pixel clock divider next value
   always_comb begin
      if (div_r == D_LAST) begin
         div_s = {DW{1'b0}};
      end else begin
         div_s = div_r + DW'(1);
      end
   end

   // Raster walk, frame wait and output next values; only ticks change anything
   always_comb begin
      state_s    = state_r;
      x_s        = x_r;
      y_s        = y_r;
      wcnt_s     = wcnt_r;
      addr_s     = rd_addr;
      r_s        = r;
      g_s        = g;
      b_s        = b;
      hs_s       = hs;
      vs_s       = vs;
      hblank_s   = hblank;
      vblank_s   = vblank;
      sync_clr_s = 1'b0;
      if (ce_pix) begin
         case (state_r)
            ST_SCAN: begin
               hblank_s = x_blank_s;
               vblank_s = y_blank_s;
               hs_s     = x_sync_s;
               vs_s     = y_sync_s;
               if (active_s) begin
                  r_s    = expand5(rd_data[14:10]);
                  g_s    = expand5(rd_data[9:5]);
                  b_s    = expand5(rd_data[4:0]);
                  addr_s = rd_addr + 16'd1;
               end else begin
                  r_s = 8'd0;
                  g_s = 8'd0;
                  b_s = 8'd0;
               end
               if (x_r == X_LAST) begin
                  x_s = {XW{1'b0}};
                  if (y_r == Y_LAST) begin
                     y_s     = {YW{1'b0}};
                     state_s = ST_WAIT;
                  end else begin
                     y_s = y_r + YW'(1);
                  end
               end else begin
                  x_s = x_r + XW'(1);
               end
            end
            ST_WAIT: begin
               hblank_s = 1'b1;
               vblank_s = 1'b1;
               hs_s     = 1'b0;
               vs_s     = 1'b0;
               r_s      = 8'd0;
               g_s      = 8'd0;
               b_s      = 8'd0;
               if (sync_r || (wcnt_r == W_MAX)) begin
                  x_s        = {XW{1'b0}};
                  y_s        = {YW{1'b0}};
                  addr_s     = 16'd0;
                  wcnt_s     = {WW{1'b0}};
                  sync_clr_s = 1'b1;
                  state_s    = ST_SCAN;
               end else begin
                  wcnt_s = wcnt_r + WW'(1);
               end
            end
            default: begin
               state_s = ST_WAIT;
            end
         endcase
      end else begin
         sync_clr_s = 1'b0;
      end
   end

   // A new frame-complete write always wins over the clear at WAIT exit
   always_comb begin
      if (sync_set_s) begin
         sync_s = 1'b1;
      end else if (sync_clr_s) begin
         sync_s = 1'b0;
      end else begin
         sync_s = sync_r;
      end
   end

   // Divider and pixel enable registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         div_r  <= {DW{1'b0}};
         ce_pix <= 1'b0;
      end else begin
         div_r  <= div_s;
         ce_pix <= (div_r == {DW{1'b0}});
      end
   end

   // Scan state, counters and frame-sync flag
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_WAIT;
         wcnt_r  <= {WW{1'b0}};
         x_r     <= {XW{1'b0}};
         y_r     <= {YW{1'b0}};
         sync_r  <= 1'b0;
         rd_addr <= 16'd0;
      end else begin
         state_r <= state_s;
         wcnt_r  <= wcnt_s;
         x_r     <= x_s;
         y_r     <= y_s;
         sync_r  <= sync_s;
         rd_addr <= addr_s;
      end
   end

   // Registered video outputs
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r      <= 8'd0;
         g      <= 8'd0;
         b      <= 8'd0;
         hs     <= 1'b0;
         vs     <= 1'b0;
         hblank <= 1'b1;
         vblank <= 1'b1;
      end else begin
         r      <= r_s;
         g      <= g_s;
         b      <= b_s;
         hs     <= hs_s;
         vs     <= vs_s;
         hblank <= hblank_s;
         vblank <= vblank_s;
      end
   end

   gba_video_scan_chk #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_chk (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce_pix  (ce_pix),
      .rd_addr (rd_addr),
      .r       (r),
      .g       (g),
      .b       (b),
      .hblank  (hblank),
      .vblank  (vblank),
      .de      (de)
   );

endmodule

// Structural invariants of the scan-out outputs.
module gba_video_scan_chk #(
   parameter int H_ACTIVE = 240,
   parameter int V_ACTIVE = 160
) (
   input logic        clk_sys,
   input logic        reset_n,
   input logic        ce_pix,
   input logic [15:0] rd_addr,
   input logic [7:0]  r,
   input logic [7:0]  g,
   input logic [7:0]  b,
   input logic        hblank,
   input logic        vblank,
   input logic        de
);

   a_ce_one_wide: assert property (@(posedge clk_sys) disable iff (!reset_n)
      ce_pix |=> !ce_pix);

   a_de_derived: assert property (@(posedge clk_sys) disable iff (!reset_n)
      de == ~(hblank | vblank));

   a_addr_bound: assert property (@(posedge clk_sys) disable iff (!reset_n)
      rd_addr <= 16'(H_ACTIVE * V_ACTIVE));

   a_blank_black: assert property (@(posedge clk_sys) disable iff (!reset_n)
      !de |-> (r == 8'd0 && g == 8'd0 && b == 8'd0));

endmodule

// File: tb/tb_gba_video_scan.sv
// Bench for gba_video_scan: per-cycle comparison against a raster-index model,
// plus a table of pixel checks on line 0 and hand-written wait/reset sequences.
module tb_gba_video_scan;

   localparam int DIV       = 4;
   localparam int HA        = 240;
   localparam int HT        = 256;
   localparam int HSS       = 244;
   localparam int HSE       = 252;
   localparam int VA        = 6;
   localparam int VT        = 10;
   localparam int VSS       = 7;
   localparam int VSE       = 8;
   localparam int FB_SIZE   = HA * VA;
   localparam int FL        = FB_SIZE - 1;
   localparam int WM        = 15;
   localparam int FRAME_PIX = HT * VT;
   localparam int AW        = $clog2(FB_SIZE);
   localparam logic [63:0] RESET_VEC = 64'h6;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        pixel_we;
   logic [15:0] pixel_addr;
   logic [15:0] rd_addr;
   logic [14:0] rd_data;
   logic        ce_pix;
   logic [7:0]  r, g, b;
   logic        hs, vs, hblank, vblank, de;

   int n_tests = 0;
   int n_fail  = 0;

   gba_video_scan #(
      .DIV (DIV), .H_ACTIVE (HA), .H_TOTAL (HT), .HS_START (HSS), .HS_END (HSE),
      .V_ACTIVE (VA), .V_TOTAL (VT), .VS_START (VSS), .VS_END (VSE),
      .FRAME_LAST (FL), .WAIT_MAX (WM)
   ) dut (
      .clk_sys (clk_sys), .reset_n (reset_n), .pixel_we (pixel_we),
      .pixel_addr (pixel_addr), .rd_addr (rd_addr), .rd_data (rd_data),
      .ce_pix (ce_pix), .r (r), .g (g), .b (b), .hs (hs), .vs (vs),
      .hblank (hblank), .vblank (vblank), .de (de)
   );

   always #5 clk_sys = ~clk_sys;

   logic [14:0] fb [0:FB_SIZE-1];

   // Framebuffer read port with one clock of latency
   always @(posedge clk_sys) begin
      if (rd_addr < 16'(FB_SIZE)) rd_data <= fb[rd_addr[AW-1:0]];
      else                        rd_data <= 15'h0;
   end

   // Reference model: raster index p within the frame, wait-tick count, pending sync
   int   m_k, m_p, m_wt, m_tick_p, e_addr;
   bit   m_scan, m_pend, m_tick, m_ticked_scan;
   bit   e_ce, e_hs, e_vs, e_hb, e_vb;
   logic [7:0] e_r, e_g, e_b;

   function automatic logic [7:0] exp5(input int c);
      return 8'(c * 8 + c / 4);
   endfunction

   task automatic model_reset();
      m_k = 0; m_p = 0; m_wt = 0; m_tick_p = -1; e_addr = 0;
      m_scan = 0; m_pend = 0; m_tick = 0; m_ticked_scan = 0;
      e_ce = 0; e_hs = 0; e_vs = 0; e_hb = 1; e_vb = 1;
      e_r = 8'd0; e_g = 8'd0; e_b = 8'd0;
   endtask

   task automatic model_edge(input bit sync_w);
      int x, y, a;
      logic [14:0] px;
      m_tick = 0;
      m_ticked_scan = 0;
      m_k++;
      if (m_k >= 2 && (m_k - 1) % DIV == 1) begin
         m_tick = 1;
         if (m_scan) begin
            x = m_p % HT;
            y = m_p / HT;
            e_hb = (x >= HA);
            e_vb = (y >= VA);
            e_hs = (x >= HSS && x < HSE);
            e_vs = (y >= VSS && y < VSE);
            if (x < HA && y < VA) begin
               a = y * HA + x;
               px = fb[AW'(a)];
               e_r = exp5(int'(px[14:10]));
               e_g = exp5(int'(px[9:5]));
               e_b = exp5(int'(px[4:0]));
               e_addr = a + 1;
            end else begin
               e_r = 8'd0; e_g = 8'd0; e_b = 8'd0;
            end
            m_ticked_scan = 1;
            m_tick_p = m_p;
            m_p++;
            if (m_p == FRAME_PIX) begin
               m_p = 0;
               m_scan = 0;
            end
         end else begin
            e_hb = 1; e_vb = 1; e_hs = 0; e_vs = 0;
            e_r = 8'd0; e_g = 8'd0; e_b = 8'd0;
            if (m_pend || m_wt == WM) begin
               m_scan = 1; m_p = 0; m_wt = 0; m_pend = 0; e_addr = 0;
            end else begin
               m_wt++;
            end
         end
      end
      if (sync_w) m_pend = 1;
      e_ce = (m_k % DIV == 1);
   endtask

   function automatic bit next_is_tick();
      return (m_k + 1 >= 2) && (m_k % DIV == 1);
   endfunction

   function automatic logic [63:0] dut_vec();
      return {18'd0, ce_pix, rd_addr, r, g, b, hs, vs, hblank, vblank, de};
   endfunction

   function automatic logic [63:0] exp_vec();
      return {18'd0, e_ce, 16'(e_addr), e_r, e_g, e_b, e_hs, e_vs, e_hb, e_vb, ~(e_hb | e_vb)};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic step(input bit we, input logic [15:0] addr);
      pixel_we   = we;
      pixel_addr = addr;
      @(posedge clk_sys);
      if (reset_n) model_edge(we && addr == 16'(FL));
      else         model_reset();
      #1;
      check("outputs", dut_vec(), exp_vec());
      pixel_we = 1'b0;
   endtask

   task automatic step_noise();
      step($urandom_range(0, 5) == 0, 16'($urandom_range(0, FL - 1)));
   endtask

   task automatic run_to_pixel(input int pix);
      int guard;
      guard = 0;
      while (!(m_ticked_scan && m_tick_p == pix) && guard < FRAME_PIX * DIV * 2) begin
         step_noise();
         guard++;
      end
      if (!(m_ticked_scan && m_tick_p == pix)) begin
         n_tests++;
         n_fail++;
         $display("FAIL run_to_pixel %0d: budget expired", pix);
      end
   endtask

   // Count ticks from the end of a frame until the DUT shows an active pixel
   task automatic measure_wait(input bit write_at_exit, output int n);
      int guard;
      guard = 0;
      n = 0;
      do begin
         if (write_at_exit && next_is_tick() && !m_scan && m_wt == WM) step(1'b1, 16'(FL));
         else step(1'b0, 16'h0);
         if (m_tick) n++;
         guard++;
      end while (de !== 1'b1 && guard < (WM + 4) * DIV * 2);
   endtask

   typedef struct {
      int          pix;
      logic [14:0] data;
      logic [7:0]  er, eg, eb;
      logic        ehs, ehb;
   } vec_t;

   vec_t tbl [14];

   initial begin
      int n, cnt;
      tbl[0]  = '{0,   15'h7FFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
      tbl[1]  = '{1,   15'h0421, 8'h08, 8'h08, 8'h08, 1'b0, 1'b0};
      tbl[2]  = '{2,   15'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[3]  = '{3,   15'h7C00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[4]  = '{4,   15'h03E0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{5,   15'h001F, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
      tbl[6]  = '{6,   15'h4210, 8'h84, 8'h84, 8'h84, 1'b0, 1'b0};
      tbl[7]  = '{7,   15'h294A, 8'h52, 8'h52, 8'h52, 1'b0, 1'b0};
      tbl[8]  = '{239, 15'h7FFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
      tbl[9]  = '{240, 15'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[10] = '{243, 15'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[11] = '{244, 15'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
      tbl[12] = '{251, 15'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
      tbl[13] = '{252, 15'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};

      for (int i = 0; i < FB_SIZE; i++) fb[AW'(i)] = 15'($urandom);
      for (int i = 0; i < 14; i++) if (tbl[i].pix < HA) fb[AW'(tbl[i].pix)] = tbl[i].data;

      reset_n    = 1'b0;
      pixel_we   = 1'b0;
      pixel_addr = 16'h0;
      model_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0);
      check("reset_state", dut_vec(), RESET_VEC);

      // Frame 1: sync immediately after reset
      reset_n = 1'b1;
      step(1'b1, 16'(FL));
      cnt = 0;
      while (de !== 1'b1 && cnt < 4 * DIV) begin
         step(1'b0, 16'h0);
         cnt++;
      end
      check("frame_start", 64'(cnt), 64'(DIV + 1));

      for (int i = 0; i < 14; i++) begin
         run_to_pixel(tbl[i].pix);
         check($sformatf("tbl%0d_rgb", i), 64'({r, g, b}), 64'({tbl[i].er, tbl[i].eg, tbl[i].eb}));
         check($sformatf("tbl%0d_hs", i), 64'(hs), 64'(tbl[i].ehs));
         check($sformatf("tbl%0d_hblank", i), 64'(hblank), 64'(tbl[i].ehb));
      end

      run_to_pixel((VA - 1) * HT + HA - 2);
      check("last_addr", 64'(rd_addr), 64'(FB_SIZE - 1));
      run_to_pixel(VA * HT);
      check("vblank_start", 64'({vblank, vs}), 64'(2'b10));
      run_to_pixel(VSS * HT);
      check("vs_rise", 64'({vblank, vs}), 64'(2'b11));
      run_to_pixel(VSE * HT - 1);
      check("vs_hold", 64'(vs), 64'(1));
      run_to_pixel(VSE * HT);
      check("vs_fall", 64'(vs), 64'(0));

      // Sync arrives during SCAN: held, WAIT lasts one tick
      run_to_pixel(FRAME_PIX - 100);
      step(1'b1, 16'(FL));
      run_to_pixel(FRAME_PIX - 1);
      measure_wait(1'b0, n);
      check("wait_sync", 64'(n), 64'(2));

      // Frame 2: no sync, timeout; sync lands on the exit tick itself
      run_to_pixel(FRAME_PIX - 1);
      measure_wait(1'b1, n);
      check("wait_timeout", 64'(n), 64'(WM + 2));

      // Frame 3: flag survived the exit, so one WAIT tick
      run_to_pixel(FRAME_PIX - 1);
      measure_wait(1'b0, n);
      check("wait_held", 64'(n), 64'(2));

      // Frame 4: asynchronous reset mid-frame
      run_to_pixel(3 * HT + 10);
      reset_n = 1'b0;
      #1;
      check("async_reset", dut_vec(), RESET_VEC);
      model_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0);
      reset_n = 1'b1;
      measure_wait(1'b0, n);
      check("wait_after_reset", 64'(n), 64'(WM + 2));
      check("restart_addr", 64'(rd_addr), 64'(1));
      run_to_pixel(HT + 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
